// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Bus between the serial receiver / CPU side and the receive FIFO.
//   master : drives rx_valid, rx_data, rd_en, clr_overrun; observes status
//   slave  : the FIFO itself; drives rd_data, empty, full, count, overrun, irq
// Parameter DEPTH sizes the count field (log2(DEPTH)+1 bits).
interface uart_rx_fifo_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rd_en;
   logic          clr_overrun;
   logic [7:0]    rd_data;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;
   logic          overrun;
   logic          irq;

   modport master (
      output rx_valid, rx_data, rd_en, clr_overrun,
      input  rd_data, empty, full, count, overrun, irq
   );

   modport slave (
      input  rx_valid, rx_data, rd_en, clr_overrun,
      output rd_data, empty, full, count, overrun, irq
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte FIFO between the UART receiver and the CPU I/O port.
// Every rx_valid strobe is captured; the oldest byte is presented on rd_data
// (first-word fall-through, 8'h00 when empty) and popped with rd_en.
// A byte arriving while full (with no simultaneous pop) is dropped and sets
// the sticky overrun flag.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   bus (slave)  rx_valid/rx_data in, rd_en/clr_overrun in,
//                rd_data/empty/full/count/overrun/irq out
// Parameters: DEPTH (power of two, >= 2), IRQ_LEVEL (1..DEPTH)
// Optional feature macro: UART_RX_FIFO_IRQ_EN
//   defined     -> irq = registered (count >= IRQ_LEVEL) | overrun
//   not defined -> irq tied low, no threshold comparator
module uart_rx_fifo #(
   parameter int DEPTH     = 16,
   parameter int IRQ_LEVEL = 1
) (
   input  logic            clk,
   input  logic            rst,
   uart_rx_fifo_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Elaboration-time parameter sanity check.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
       (IRQ_LEVEL < 1) || (IRQ_LEVEL > DEPTH)) begin : g_bad_param
      $error("uart_rx_fifo: illegal DEPTH/IRQ_LEVEL");
   end

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wp_r;
   logic [AW-1:0] rp_r;
   logic [CW-1:0] cnt_r;
   logic          overrun_r;
   logic          irq_r;

   logic          pop_s;
   logic          push_s;
   logic          drop_s;
   logic [CW-1:0] cnt_nxt_s;
   logic          overrun_nxt_s;
   logic          irq_nxt_s;
   logic          empty_s;
   logic          full_s;

   assign empty_s = (cnt_r == CW'(0));
   assign full_s  = (cnt_r == CW'(DEPTH));

   // Push/pop qualification, next occupancy and next flag values.
   always_comb begin
      pop_s         = 1'b0;
      push_s        = 1'b0;
      drop_s        = 1'b0;
      cnt_nxt_s     = cnt_r;
      overrun_nxt_s = overrun_r;
      irq_nxt_s     = 1'b0;

      pop_s  = bus.rd_en & ~empty_s;
      // A full FIFO can still accept a byte when the head leaves the same cycle.
      push_s = bus.rx_valid & (~full_s | pop_s);
      drop_s = bus.rx_valid & ~push_s;

      case ({push_s, pop_s})
         2'b10:   cnt_nxt_s = cnt_r + CW'(1);
         2'b01:   cnt_nxt_s = cnt_r - CW'(1);
         default: cnt_nxt_s = cnt_r;
      endcase

      // Drop wins over a simultaneous clear so no overrun event is lost.
      if (drop_s) begin
         overrun_nxt_s = 1'b1;
      end else if (bus.clr_overrun) begin
         overrun_nxt_s = 1'b0;
      end else begin
         overrun_nxt_s = overrun_r;
      end

`ifdef UART_RX_FIFO_IRQ_EN
      irq_nxt_s = (cnt_nxt_s >= CW'(IRQ_LEVEL)) | overrun_nxt_s;
`else
      irq_nxt_s = 1'b0;
`endif
   end

   // Pointer, occupancy and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_r      <= AW'(0);
         rp_r      <= AW'(0);
         cnt_r     <= CW'(0);
         overrun_r <= 1'b0;
         irq_r     <= 1'b0;
      end else begin
         if (push_s) begin
            wp_r <= wp_r + AW'(1);
         end
         if (pop_s) begin
            rp_r <= rp_r + AW'(1);
         end
         cnt_r     <= cnt_nxt_s;
         overrun_r <= overrun_nxt_s;
         irq_r     <= irq_nxt_s;
      end
   end

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wp_r] <= bus.rx_data;
      end
   end

   assign bus.rd_data = empty_s ? 8'h00 : mem_r[rp_r];
   assign bus.empty   = empty_s;
   assign bus.full    = full_s;
   assign bus.count   = cnt_r;
   assign bus.overrun = overrun_r;
   assign bus.irq     = irq_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo (DEPTH=16). Accepted pushes place the
// expected byte into a scoreboard queue; an independent monitor pops and
// compares rd_data whenever the DUT accepts a pop (rd_en with empty=0).
// Status flags are checked with hand-computed constants after each step.
// With UART_RX_FIFO_IRQ_EN defined, IRQ_LEVEL=4 and the irq threshold is tested.
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_IRQ_EN
   localparam int IRQ_LEVEL = 4;
`else
   localparam int IRQ_LEVEL = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q [$];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: compares the head byte on every accepted pop.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.rd_en && !bus.empty) begin
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", 1, 0);
            end else begin
               chk("pop_data", int'(bus.rd_data), int'(exp_q.pop_front()));
            end
         end
      end
   end

   // One clock of stimulus; acc says whether the push is expected to be kept.
   task automatic step(input logic v, input logic [7:0] d, input logic r,
                       input logic c, input logic acc);
      bus.rx_valid    = v;
      bus.rx_data     = d;
      bus.rd_en       = r;
      bus.clr_overrun = c;
      if (acc) exp_q.push_back(d);
      @(posedge clk);
      #1;
      bus.rx_valid    = 1'b0;
      bus.rx_data     = 8'h00;
      bus.rd_en       = 1'b0;
      bus.clr_overrun = 1'b0;
   endtask

   task automatic chk_stat(input string tag, input int cnt, input int emp,
                           input int ful, input int ovr, input int rdd);
      chk({tag, "_count"},   int'(bus.count),   cnt);
      chk({tag, "_empty"},   int'(bus.empty),   emp);
      chk({tag, "_full"},    int'(bus.full),    ful);
      chk({tag, "_overrun"}, int'(bus.overrun), ovr);
      chk({tag, "_rd_data"}, int'(bus.rd_data), rdd);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
   endtask

   initial begin
      bus.rx_valid    = 1'b0;
      bus.rx_data     = 8'h00;
      bus.rd_en       = 1'b0;
      bus.clr_overrun = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_stat("reset", 0, 1, 0, 0, 8'h00);
      chk("reset_irq", int'(bus.irq), 0);
      rst = 1'b0;

      // Single byte in and out
      step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
      chk_stat("push_a5", 1, 0, 0, 0, 8'hA5);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk_stat("pop_a5", 0, 1, 0, 0, 8'h00);

      // Fill to DEPTH
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
      chk_stat("fill", 16, 0, 1, 0, 8'h01);
`ifdef UART_RX_FIFO_IRQ_EN
      chk("fill_irq", int'(bus.irq), 1);
`else
      chk("fill_irq_off", int'(bus.irq), 0);
`endif

      // Drop while full, then clear interaction
      step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      chk_stat("drop", 16, 0, 1, 1, 8'h01);
      step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
      chk_stat("drop_clr", 16, 0, 1, 1, 8'h01);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk_stat("clr", 16, 0, 1, 0, 8'h01);

      // Full + push + pop: both accepted
      step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
      chk_stat("full_pushpop", 16, 0, 1, 0, 8'h02);
      for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk_stat("drain15", 1, 0, 0, 0, 8'h77);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk_stat("drain_last", 0, 1, 0, 0, 8'h00);

      // Empty + push + pop: pop ignored
      step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
      chk_stat("empty_pushpop", 1, 0, 0, 0, 8'h5A);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Pops on empty are ignored
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk_stat("pop_empty", 0, 1, 0, 0, 8'h00);
      step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
      chk_stat("push_3c", 1, 0, 0, 0, 8'h3C);

      // Push every cycle with concurrent pops (occupancy holds at 1)
      step(1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
      step(1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
      step(1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
      chk_stat("stream", 1, 0, 0, 0, 8'h33);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("stream_drained", exp_q.size(), 0);

`ifdef UART_RX_FIFO_IRQ_EN
      // Threshold interrupt at IRQ_LEVEL=4
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
      chk("irq_at3", int'(bus.irq), 0);
      step(1'b1, 8'h43, 1'b0, 1'b0, 1'b1);
      chk("irq_at4", int'(bus.irq), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("irq_pop3", int'(bus.irq), 0);
      step(1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h45, 1'b0, 1'b0, 1'b1);
      chk("irq_at5", int'(bus.irq), 1);
`else
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
`endif
      chk("pre_rst_count", int'(bus.count), 5);

      // Asynchronous reset mid-operation takes effect without a clock edge
      async_reset();
      chk_stat("mid_rst", 0, 1, 0, 0, 8'h00);
      chk("mid_rst_irq", int'(bus.irq), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
      chk_stat("post_rst", 1, 0, 0, 0, 8'hC3);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("final_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
